// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Single-outstanding-request instruction fetch unit. It reads 16-bit
// instructions from an instruction memory with a req/ack handshake and shows
// them to the core one at a time. It supports stall back-pressure and
// single-cycle branch redirects.
//
// Ports
//   clk            : single clock, all state changes on the rising edge
//   rst_n          : asynchronous active-low reset
//   en             : run enable; high permits new fetches
//   stall          : core not ready; holds the presented instruction
//   branch_valid   : one-cycle redirect request
//   branch_target  : redirect address (PC_W bits)
//   imem_req       : instruction-memory read request
//   imem_addr      : instruction-memory read address (PC_W bits)
//   imem_ack       : read data valid this cycle
//   imem_rdata     : read data (16 bits)
//   instra         : instruction to core, opcode in bits [3:0]
//   instr_valid    : instra holds a live instruction
//   pc_out         : address of the instruction on instra
//
// Operation
//   IDLE  -> FETCH when en is high.
//   FETCH holds req/addr steady until ack. A good ack loads instra and moves
//         to HOLD.
//   HOLD  presents the instruction until the core takes it (stall low) or a
//         branch flushes it.
//
//   A branch while a request is outstanding cannot withdraw that request. The
//   new pc is taken right away, and the old address is kept so that imem_addr
//   stays stable. The ack for the old request is then discarded. After any
//   discarded ack, the unit spends one FETCH cycle with imem_req low (the
//   "bubble") before it issues the redirected request.
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            stall,
  input  logic            branch_valid,
  input  logic [PC_W-1:0] branch_target,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic [15:0]     instra,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Registered state
  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_sq_addr;     // address of a request that a branch overtook
  logic            r_squash;      // outstanding request is stale; drop its ack
  logic            r_bubble;      // one idle FETCH cycle after a dropped ack
  logic [15:0]     r_instra;
  logic            r_instr_valid;
  logic [PC_W-1:0] r_pc_out;

  // Next-state values
  state_t          w_state_nxt;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_sq_addr_nxt;
  logic            w_squash_nxt;
  logic            w_bubble_nxt;
  logic [15:0]     w_instra_nxt;
  logic            w_valid_nxt;
  logic [PC_W-1:0] w_pc_out_nxt;

  // Request is live only in FETCH and outside the bubble. An ack is counted
  // only against a live request, so an ack at any other time is ignored.
  logic            w_req;
  logic            w_ack;

  assign w_req = (r_state == ST_FETCH) && !r_bubble;
  assign w_ack = w_req && imem_ack;

  // While a squashed request is still outstanding, keep presenting its
  // original address. r_pc already holds the branch target.
  assign imem_req    = w_req;
  assign imem_addr   = r_squash ? r_sq_addr : r_pc;
  assign instra      = r_instra;
  assign instr_valid = r_instr_valid;
  assign pc_out      = r_pc_out;

  // ---------------------------------------------------------------------------
  // Next-state / datapath decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_sq_addr_nxt = r_sq_addr;
    w_squash_nxt  = r_squash;
    w_bubble_nxt  = 1'b0;
    w_instra_nxt  = r_instra;
    w_valid_nxt   = r_instr_valid;
    w_pc_out_nxt  = r_pc_out;

    case (r_state)
      ST_IDLE: begin
        w_valid_nxt  = 1'b0;
        w_squash_nxt = 1'b0;
        if (branch_valid) begin
          w_pc_nxt = branch_target;
        end
        if (en) begin
          w_state_nxt = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (r_bubble) begin
          // No request is in flight, so a redirect only moves the pc.
          if (branch_valid) begin
            w_pc_nxt = branch_target;
          end
        end else if (w_ack) begin
          if (branch_valid) begin
            // Redirect arriving with the data: drop the data, take the target.
            w_pc_nxt     = branch_target;
            w_squash_nxt = 1'b0;
            w_bubble_nxt = 1'b1;
          end else if (r_squash) begin
            // Late data for an overtaken request: the pc is already the target.
            w_squash_nxt = 1'b0;
            w_bubble_nxt = 1'b1;
          end else begin
            w_instra_nxt = imem_rdata;
            w_pc_out_nxt = r_pc;
            w_pc_nxt     = r_pc + 1'b1;   // wraps modulo 2^PC_W
            w_valid_nxt  = 1'b1;
            w_state_nxt  = ST_HOLD;
          end
        end else if (branch_valid) begin
          // The request cannot be withdrawn. Remember its address only on
          // the first overtaking branch; later branches just move the pc.
          w_pc_nxt     = branch_target;
          w_squash_nxt = 1'b1;
          if (!r_squash) begin
            w_sq_addr_nxt = r_pc;
          end
        end
        // en is ignored here, so an outstanding request always completes.
      end

      ST_HOLD: begin
        // A branch flushes the held instruction even while stalled.
        if (branch_valid || !stall) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = en ? ST_FETCH : ST_IDLE;
          if (branch_valid) begin
            w_pc_nxt = branch_target;
          end
        end
      end

      default: begin
        w_state_nxt  = ST_IDLE;
        w_valid_nxt  = 1'b0;
        w_squash_nxt = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_sq_addr     <= RESET_PC;
      r_squash      <= 1'b0;
      r_bubble      <= 1'b0;
      r_instra      <= 16'h0000;
      r_instr_valid <= 1'b0;
      r_pc_out      <= RESET_PC;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_sq_addr     <= w_sq_addr_nxt;
      r_squash      <= w_squash_nxt;
      r_bubble      <= w_bubble_nxt;
      r_instra      <= w_instra_nxt;
      r_instr_valid <= w_valid_nxt;
      r_pc_out      <= w_pc_out_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Scoreboard bench for instr_fetch. The stimulus process plays the role of the
// instruction memory. Each time the memory answers a request that the fetch
// rules say must be delivered, it pushes the expected {pc, data} pair. The
// pair comes from a simple program-order model: the next address is the last
// branch target, or else the previous delivered address + 1. A separate
// monitor pops one pair each time a new instruction appears on instra.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam int        PC_W     = 8;
  localparam logic [7:0] RESET_PC = 8'h00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        stall;
  logic        branch_valid;
  logic [7:0]  branch_target;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instra;
  logic        instr_valid;
  logic [7:0]  pc_out;

  always #5 clk = ~clk;

  instr_fetch #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .stall         (stall),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instra        (instra),
    .instr_valid   (instr_valid),
    .pc_out        (pc_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] data;
  } exp_t;

  logic [15:0] mem [256];
  exp_t        sbq[$];
  logic [7:0]  pres_hist[$];

  // Program-order reference model
  logic [7:0] m_pc      = RESET_PC;
  bit         m_tainted = 1'b0;   // a branch arrived while this request was in flight
  int         reqcyc    = 0;
  int         lat       = 1;
  int         lat_fix   = 1;
  logic [7:0] req_addr  = '0;
  bit         stray_en  = 1'b0;
  bit         br_on_ack = 1'b0;
  logic [7:0] br_ack_tgt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick_lat();
    return (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 2));
  endfunction

  task automatic set_lat(input int n);
    lat_fix = n;
    if (reqcyc == 0) lat = pick_lat();
  endtask

  task automatic model_reset();
    sbq.delete();
    m_pc      = RESET_PC;
    m_tainted = 1'b0;
    reqcyc    = 0;
    lat       = pick_lat();
  endtask

  // One clock cycle. It is called at posedge+1, drives the inputs and the
  // memory response, then waits for the edge and advances the model.
  task automatic step(input bit e, input bit s, input bit b, input logic [7:0] t);
    bit req_c;
    bit ack_c;
    exp_t x;
    en            = e;
    stall         = s;
    branch_valid  = b;
    branch_target = t;
    imem_ack      = 1'b0;
    imem_rdata    = 16'($urandom);
    req_c = rst_n && imem_req;
    if (req_c) begin
      if (reqcyc == 0) begin
        chk("req_addr", 32'(imem_addr), 32'(m_pc));
        req_addr = imem_addr;
      end else begin
        chk("req_addr_stable", 32'(imem_addr), 32'(req_addr));
      end
      if (reqcyc >= lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem[imem_addr];
        if (br_on_ack) begin
          branch_valid  = 1'b1;
          branch_target = br_ack_tgt;
          br_on_ack     = 1'b0;
        end
      end
    end else if (stray_en && instr_valid && $urandom_range(0, 9) == 0) begin
      imem_ack   = 1'b1;
      imem_rdata = 16'hBAD0;
    end
    ack_c = req_c && imem_ack;
    @(posedge clk);
    if (ack_c) begin
      if (!m_tainted && !branch_valid) begin
        x.pc   = m_pc;
        x.data = mem[m_pc];
        sbq.push_back(x);
        m_pc = m_pc + 8'd1;
      end
      m_tainted = 1'b0;
      reqcyc    = 0;
      lat       = pick_lat();
    end else if (req_c) begin
      reqcyc++;
    end
    if (branch_valid) begin
      m_pc = branch_target;
      if (req_c && !ack_c) m_tainted = 1'b1;
    end
    #1;
  endtask

  // Monitor: runs on the falling edge, away from the active edge.
  logic        p_valid = 1'b0;
  logic        p_stall = 1'b0;
  logic        p_br    = 1'b0;
  logic [15:0] p_instra = '0;
  logic [7:0]  p_pc     = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      p_valid = 1'b0;
    end else begin
      if (instr_valid && !p_valid) begin
        pres_hist.push_back(pc_out);
        n_checks++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_instr: got pc %0h data %0h, expected none", pc_out, instra);
        end else begin
          e = sbq.pop_front();
          chk("pc_out", 32'(pc_out), 32'(e.pc));
          chk("instra", 32'(instra), 32'(e.data));
        end
      end
      if (p_valid && instr_valid) begin
        chk("hold_instra", 32'(instra), 32'(p_instra));
        chk("hold_pc_out", 32'(pc_out), 32'(p_pc));
      end
      if (p_valid) begin
        chk("valid_after_hold", 32'(instr_valid), (p_stall && !p_br) ? 32'd1 : 32'd0);
      end
      if (instr_valid) chk("no_req_in_hold", 32'(imem_req), 32'd0);
      p_valid  = instr_valid;
      p_stall  = stall;
      p_br     = branch_valid;
      p_instra = instra;
      p_pc     = pc_out;
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0013;
    mem[1] = 16'h0025;
    mem[2] = 16'h0014;
    mem[3] = 16'h0033;

    rst_n = 1'b0; en = 1'b0; stall = 1'b0; branch_valid = 1'b0;
    branch_target = '0; imem_ack = 1'b0; imem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",   32'(imem_req),    32'd0);
    chk("rst_addr",  32'(imem_addr),   32'(RESET_PC));
    chk("rst_instra",32'(instra),      32'h0000);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc_out",32'(pc_out),      32'(RESET_PC));
    model_reset();
    set_lat(1);
    pres_hist.delete();
    rst_n = 1'b1;

    // Two back-to-back instructions with no stall
    repeat (7) step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("two_presented", 32'(pres_hist.size() >= 2), 32'd1);
    if (pres_hist.size() >= 2) begin
      chk("first_pc",  32'(pres_hist[0]), 32'h00);
      chk("second_pc", 32'(pres_hist[1]), 32'h01);
    end

    // Stall for 5 cycles on the addr-2 instruction
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (instr_valid && pc_out == 8'h02) begin found = 1'b1; break; end
      step(1'b1, 1'b0, 1'b0, 8'h00);
    end
    chk("reach_hold_addr2", 32'(found), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_instra", 32'(instra), 32'h0014);
      chk("stall_no_req", 32'(imem_req), 32'd0);
      step(1'b1, 1'b1, 1'b0, 8'h00);
    end
    set_lat(2);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("fetch_after_stall_req",  32'(imem_req),  32'd1);
    chk("fetch_after_stall_addr", 32'(imem_addr), 32'h03);

    // Branch to 0x40 while addr 3 is outstanding, ack 2 cycles later
    step(1'b1, 1'b0, 1'b1, 8'h40);
    set_lat(1);
    pres_hist.delete();
    repeat (8) step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("after_squash_presented", 32'(pres_hist.size() >= 1), 32'd1);
    if (pres_hist.size() >= 1) chk("after_squash_pc", 32'(pres_hist[0]), 32'h40);

    // Branch to 0x10 in the same cycle as an ack
    br_on_ack  = 1'b1;
    br_ack_tgt = 8'h10;
    for (int i = 0; i < 10 && br_on_ack; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("br_with_ack_fired", 32'(br_on_ack), 32'd0);
    pres_hist.delete();
    repeat (8) step(1'b1, 1'b0, 1'b0, 8'h00);
    if (pres_hist.size() >= 1) chk("br_ack_next_pc", 32'(pres_hist[0]), 32'h10);
    else chk("br_ack_presented", 32'd0, 32'd1);

    // PC wrap: 0xFF followed by 0x00
    step(1'b1, 1'b0, 1'b1, 8'hFF);
    pres_hist.delete();
    repeat (14) step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("wrap_presented", 32'(pres_hist.size() >= 2), 32'd1);
    if (pres_hist.size() >= 2) begin
      chk("wrap_pc_ff", 32'(pres_hist[0]), 32'hFF);
      chk("wrap_pc_00", 32'(pres_hist[1]), 32'h00);
    end

    // Reset while a request to addr 5 is outstanding
    set_lat(3);
    step(1'b1, 1'b0, 1'b1, 8'h05);
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (imem_req && imem_addr == 8'h05) begin found = 1'b1; break; end
      step(1'b1, 1'b0, 1'b0, 8'h00);
    end
    chk("reach_req_addr5", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_req",    32'(imem_req),    32'd0);
    chk("async_rst_instra", 32'(instra),      32'h0000);
    chk("async_rst_valid",  32'(instr_valid), 32'd0);
    chk("async_rst_addr",   32'(imem_addr),   32'(RESET_PC));
    chk("async_rst_pc_out", 32'(pc_out),      32'(RESET_PC));
    en = 1'b0; branch_valid = 1'b0;
    imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;       // stray ack while IDLE
    imem_ack = 1'b0;
    chk("stray_ack_valid", 32'(instr_valid), 32'd0);
    chk("stray_ack_req",   32'(imem_req),    32'd0);
    set_lat(-1);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("restart_req",  32'(imem_req),  32'd1);
    chk("restart_addr", 32'(imem_addr), 32'(RESET_PC));

    // Randomised traffic
    stray_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] tgt;
      tgt = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 4,
           $urandom_range(0, 99) < 8, tgt);
    end

    // Drain: everything the model expects must have been delivered
    stray_en = 1'b0;
    repeat (20) step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("queue_drained", 32'(sbq.size()), 32'd0);
    chk("drain_idle_req", 32'(imem_req), 32'd0);
    chk("drain_valid",    32'(instr_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter PC_W, default 8, program-counter and instruction-memory address width.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port en  input  1  run enable; high permits new fetches.
REQ-006 Port stall  input  1  downstream core not ready; holds the presented instruction.
REQ-007 Port branch_valid  input  1  one-cycle redirect request.
REQ-008 Port branch_target  input  PC_W  redirect address.
REQ-009 Port imem_req  output  1  instruction-memory read request.
REQ-010 Port imem_addr  output  PC_W  instruction-memory read address.
REQ-011 Port imem_ack  input  1  read data valid this cycle.
REQ-012 Port imem_rdata  input  16  read data.
REQ-013 Port instra  output  16  instruction to core; opcode in bits [3:0].
REQ-014 Port instr_valid  output  1  instra holds a live instruction.
REQ-015 Port pc_out  output  PC_W  address of the instruction on instra.

Function
REQ-016 States SHALL be IDLE, FETCH, HOLD; state, pc, instra, instr_valid, pc_out, squash SHALL all be registers.
REQ-017 IDLE: imem_req=0, instr_valid=0; en=1 -> FETCH next cycle.
REQ-018 FETCH: imem_req=1, imem_addr=pc, both SHALL stay stable until the imem_ack cycle.
REQ-019 FETCH with imem_ack=1, squash=0, branch_valid=0: instra<=imem_rdata, pc_out<=pc, pc<=pc+1 modulo 2^PC_W (all-ones wraps to 0), instr_valid<=1, -> HOLD.
REQ-020 HOLD: instr_valid=1, imem_req=0; instra and pc_out SHALL not change while stall=1.
REQ-021 HOLD with stall=0 consumes the instruction at that edge: instr_valid<=0; -> FETCH if en=1, else -> IDLE.
REQ-022 Minimum issue interval SHALL be 2 cycles per instruction with single-cycle imem_ack.
REQ-023 branch_valid in IDLE: pc<=branch_target, state unchanged.
REQ-024 branch_valid in HOLD: pc<=branch_target, instr_valid<=0 (flush, stall ignored); -> FETCH if en=1, else IDLE.
REQ-025 branch_valid in FETCH without imem_ack: pc<=branch_target, squash<=1; request is not withdrawn; imem_addr stays at old address until ack.
REQ-026 FETCH with imem_ack=1 and squash=1: data discarded, instr_valid stays 0, squash<=0, pc unchanged (already target), stay FETCH, imem_req=0 for one cycle.
REQ-027 FETCH with imem_ack=1 and branch_valid=1 same cycle: data discarded, pc<=branch_target, squash<=0, stay FETCH, imem_req=0 for one cycle.
REQ-028 en falling in FETCH SHALL not abort the outstanding request; completion proceeds per REQ-019 to HOLD, then IDLE on consumption.
REQ-029 imem_ack outside FETCH SHALL be ignored.

Reset
REQ-030 rst_n=0 SHALL immediately force: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instra=16'h0000, instr_valid=0, pc_out=RESET_PC, squash=0.
REQ-031 Reset mid-fetch SHALL drop imem_req asynchronously; any later imem_ack for that request is ignored per REQ-029.
REQ-032 First fetch after rst_n rises SHALL request address RESET_PC.

Verification
REQ-033 Reset, en=1, memory returns 16'h0013 at addr 0, 16'h0025 at addr 1, ack 1 cycle after req, stall=0 -> instra 16'h0013 pc_out 0, then 16'h0025 pc_out 1, instr_valid high one cycle each.
REQ-034 stall=1 for 5 cycles while HOLD with instra=16'h0014 -> instra, pc_out, instr_valid constant; no imem_req; next fetch starts after stall falls.
REQ-035 branch_valid target 8'h40 during FETCH of addr 3, ack 2 cycles later -> addr-3 data never valid; next imem_addr=8'h40.
REQ-036 branch_valid and imem_ack same cycle, target 8'h10 -> data dropped, next request addr 8'h10.
REQ-037 pc=8'hFF fetched -> pc_out 8'hFF, next imem_addr 8'h00.
REQ-038 rst_n low while imem_req=1 at addr 5 -> imem_req=0, instra=16'h0000 immediately; stray ack ignored; restart at RESET_PC.
